// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register with burst controller.
// Contents:
//   MODE_* : 3-bit operation select codes
//   usr_state_e : burst controller states
//   is_shift_mode() : modes that a burst_start may repeat as a burst
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_ZERO = 3'b111;

  typedef enum logic {
    StIdle,
    StBurst
  } usr_state_e;

  // HOLD, LOAD and ZERO are not repeatable steps, so they never start a burst.
  function automatic logic is_shift_mode(input logic [2:0] mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL) || (mode == MODE_ROR) ||
           (mode == MODE_ROL) || (mode == MODE_ASR);
  endfunction

endpackage

// File: rtl/usr_next_word.sv
// Combinational next-value selector for the universal shift register.
// Ports:
//   mode   : operation select (MODE_* codes)
//   q      : current register contents
//   par_in : parallel load data
//   msb_in : serial bit shifted into the top on SHR
//   lsb_in : serial bit shifted into the bottom on SHL
//   next_q : register value after applying mode to q
module usr_next_word
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] par_in,
  input  logic             msb_in,
  input  logic             lsb_in,
  output logic [WIDTH-1:0] next_q
);

  always_comb begin
    next_q = q;
    case (mode)
      MODE_HOLD: next_q = q;
      MODE_SHR:  next_q = {msb_in, q[WIDTH-1:1]};
      MODE_SHL:  next_q = {q[WIDTH-2:0], lsb_in};
      MODE_LOAD: next_q = par_in;
      MODE_ROR:  next_q = {q[0], q[WIDTH-1:1]};
      MODE_ROL:  next_q = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ASR:  next_q = {q[WIDTH-1], q[WIDTH-1:1]};
      MODE_ZERO: next_q = '0;
      default:   next_q = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg_burst.sv
// Universal shift register with a burst controller that repeats one shift/rotate
// operation burst_len times from a single burst_start strobe.
// Ports:
//   clk         : clock, all state changes on posedge
//   clear       : synchronous active-high reset, overrides en
//   en          : clock enable; low freezes register and burst counter
//   mode        : operation select (MODE_* codes in usr_pkg)
//   par_in      : parallel load data
//   msb_in      : serial input into the top bit on SHR
//   lsb_in      : serial input into bit 0 on SHL
//   burst_start : start a burst of the current mode (shift/rotate modes only)
//   burst_len   : number of steps in the burst
//   par_out     : register contents
//   msb_out     : par_out[WIDTH-1]
//   lsb_out     : par_out[0]
//   busy        : burst in progress
//   done        : one-cycle pulse when a burst completes
module univ_shift_reg_burst
  import usr_pkg::*;
#(
  parameter int unsigned          WIDTH     = 4,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0,
  parameter int unsigned          CNT_W     = $clog2(WIDTH) + 2
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] par_in,
  input  logic             msb_in,
  input  logic             lsb_in,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] par_out,
  output logic             msb_out,
  output logic             lsb_out,
  output logic             busy,
  output logic             done
);

  usr_state_e       state_q;
  logic [2:0]       burst_op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] q_q;
  logic             busy_q;
  logic             done_q;

  logic [2:0]       op_sel;
  logic [WIDTH-1:0] next_q;
  logic             start_ok;

  // Inside a burst the latched op drives the datapath; mode is ignored.
  assign op_sel   = (state_q == StBurst) ? burst_op_q : mode;
  assign start_ok = burst_start && is_shift_mode(mode);

  usr_next_word #(
    .WIDTH (WIDTH)
  ) u_next_word (
    .mode   (op_sel),
    .q      (q_q),
    .par_in (par_in),
    .msb_in (msb_in),
    .lsb_in (lsb_in),
    .next_q (next_q)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= StIdle;
      burst_op_q <= MODE_HOLD;
      cnt_q      <= '0;
      q_q        <= RESET_VAL;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // done is a pulse even if en drops on the following cycle.
      done_q <= 1'b0;
      if (en) begin
        unique case (state_q)
          StIdle: begin
            if (start_ok) begin
              burst_op_q <= mode;
              if (burst_len == '0) begin
                // Zero-length burst: register held, completion reported at once.
                done_q <= 1'b1;
              end else begin
                // The accepting edge already performs the first step.
                q_q <= next_q;
                if (burst_len == CNT_W'(1)) begin
                  done_q <= 1'b1;
                end else begin
                  cnt_q   <= burst_len - CNT_W'(1);
                  state_q <= StBurst;
                  busy_q  <= 1'b1;
                end
              end
            end else begin
              q_q <= next_q;
            end
          end
          StBurst: begin
            q_q   <= next_q;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign par_out = q_q;
  assign msb_out = q_q[WIDTH-1];
  assign lsb_out = q_q[0];
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_univ_shift_reg_burst.sv
module tb_univ_shift_reg_burst;

  localparam int W  = 8;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          clear;
  logic          en;
  logic [2:0]    mode;
  logic [W-1:0]  par_in;
  logic          msb_in;
  logic          lsb_in;
  logic          burst_start;
  logic [CW-1:0] burst_len;
  logic [W-1:0]  par_out;
  logic          msb_out;
  logic          lsb_out;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q;

  always #5 clk = ~clk;

  univ_shift_reg_burst #(
    .WIDTH     (W),
    .RESET_VAL (8'h00),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .clear       (clear),
    .en          (en),
    .mode        (mode),
    .par_in      (par_in),
    .msb_in      (msb_in),
    .lsb_in      (lsb_in),
    .burst_start (burst_start),
    .burst_len   (burst_len),
    .par_out     (par_out),
    .msb_out     (msb_out),
    .lsb_out     (lsb_out),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one operation, written as integer arithmetic.
  function automatic logic [7:0] model(input logic [2:0] m, input logic [7:0] v,
                                       input logic msb, input logic lsb, input logic [7:0] p);
    int x;
    int r;
    x = int'(v);
    case (m)
      3'd1:    r = (x >> 1) | (int'(msb) << 7);
      3'd2:    r = ((x << 1) & 'hFF) | int'(lsb);
      3'd3:    r = int'(p);
      3'd4:    r = (x >> 1) | ((x & 1) << 7);
      3'd5:    r = ((x << 1) & 'hFF) | (x >> 7);
      3'd6:    r = (x >> 1) | (x & 'h80);
      3'd7:    r = 0;
      default: r = x;
    endcase
    return r[7:0];
  endfunction

  function automatic bit shift_mode(input logic [2:0] m);
    return (m == 3'd1) || (m == 3'd2) || (m == 3'd4) || (m == 3'd5) || (m == 3'd6);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle operation with no burst.
  task automatic op(input logic [2:0] m, input logic [7:0] p, input logic msb, input logic lsb,
                    input logic e, input logic st, input string tag);
    mode = m; par_in = p; msb_in = msb; lsb_in = lsb; en = e; burst_start = st;
    if (e) exp_q = model(m, exp_q, msb, lsb, p);
    tick();
    burst_start = 1'b0;
    en = 1'b1;
    chk({tag, "_q"}, par_out, exp_q);
    chk({tag, "_msb"}, msb_out, exp_q[7]);
    chk({tag, "_lsb"}, lsb_out, exp_q[0]);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  // Burst of len steps of op m; the bench counts steps on en-high cycles.
  task automatic burst(input logic [2:0] m, input int len, input bit rand_en,
                       input bit rand_ser, input string tag);
    int taken;
    int cyc;
    taken = 0;
    cyc = 0;
    mode = m; burst_len = len[CW-1:0]; burst_start = 1'b1; en = 1'b1;
    if (rand_ser) begin
      msb_in = 1'($urandom); lsb_in = 1'($urandom);
    end
    if (len > 0) begin
      exp_q = model(m, exp_q, msb_in, lsb_in, par_in);
      taken = 1;
    end
    tick();
    burst_start = 1'b0;
    chk({tag, "_start_q"}, par_out, exp_q);
    chk({tag, "_start_busy"}, busy, taken < len);
    chk({tag, "_start_done"}, done, taken == len);
    while (taken < len && cyc < 200) begin
      cyc++;
      en = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      mode = 3'($urandom); par_in = 8'($urandom); burst_start = 1'($urandom);
      if (rand_ser) begin
        msb_in = 1'($urandom); lsb_in = 1'($urandom);
      end
      if (en) begin
        exp_q = model(m, exp_q, msb_in, lsb_in, par_in);
        taken++;
      end
      tick();
      chk({tag, "_q"}, par_out, exp_q);
      chk({tag, "_busy"}, busy, taken < len);
      chk({tag, "_done"}, done, en && (taken == len));
    end
    chk({tag, "_bounded"}, cyc < 200, 1'b1);
    en = 1'b1; mode = 3'd0; burst_start = 1'b0;
    tick();
    chk({tag, "_after_q"}, par_out, exp_q);
    chk({tag, "_after_busy"}, busy, 1'b0);
    chk({tag, "_after_done"}, done, 1'b0);
  endtask

  initial begin
    clear = 1'b1; en = 1'b0; mode = 3'd0; par_in = '0; msb_in = 1'b0; lsb_in = 1'b0;
    burst_start = 1'b0; burst_len = '0;
    tick();
    tick();
    exp_q = 8'h00;
    chk("reset_q", par_out, 8'h00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    clear = 1'b0;
    en = 1'b1;

    // Directed basic operations.
    op(3'd3, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, "load_a5");
    op(3'd1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, "shr_msb1");
    chk("shr_d2", par_out, 8'hD2);
    op(3'd2, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "shl_lsb0");
    chk("shl_a4", par_out, 8'hA4);
    op(3'd3, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, "load_80");
    op(3'd6, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "asr_80");
    chk("asr_c0", par_out, 8'hC0);
    op(3'd0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, "en_low_hold");
    op(3'd7, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, "zero_with_start");
    op(3'd3, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, "load_with_start");

    // ROL burst of 3 from 81.
    op(3'd3, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, "load_81");
    burst(3'd5, 3, 1'b0, 1'b0, "rol3");
    chk("rol3_0c", par_out, 8'h0C);

    // ROR burst of 9 wraps modulo width.
    op(3'd3, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, "load_01");
    burst(3'd4, 9, 1'b0, 1'b0, "ror9");
    chk("ror9_80", par_out, 8'h80);

    // Zero-length SHL burst.
    burst(3'd2, 0, 1'b0, 1'b0, "shl0");
    chk("shl0_80", par_out, 8'h80);

    // SHR burst of 4 from 0F with en low for two cycles and mode churn.
    op(3'd3, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, "load_0f");
    mode = 3'd1; msb_in = 1'b0; burst_len = 5'd4; burst_start = 1'b1; en = 1'b1;
    tick();
    burst_start = 1'b0;
    chk("shr4_s1_q", par_out, 8'h07);
    chk("shr4_s1_busy", busy, 1'b1);
    mode = 3'd3; par_in = 8'hFF;
    tick();
    chk("shr4_s2_q", par_out, 8'h03);
    en = 1'b0; mode = 3'd7;
    tick();
    chk("shr4_p1_q", par_out, 8'h03);
    chk("shr4_p1_busy", busy, 1'b1);
    tick();
    chk("shr4_p2_q", par_out, 8'h03);
    chk("shr4_p2_done", done, 1'b0);
    en = 1'b1; mode = 3'd5;
    tick();
    chk("shr4_s3_q", par_out, 8'h01);
    chk("shr4_s3_busy", busy, 1'b1);
    tick();
    chk("shr4_s4_q", par_out, 8'h00);
    chk("shr4_s4_busy", busy, 1'b0);
    chk("shr4_s4_done", done, 1'b1);
    mode = 3'd0;
    tick();
    chk("shr4_after_done", done, 1'b0);
    exp_q = 8'h00;

    // Clear aborts a burst with no done pulse.
    op(3'd3, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, "load_5a");
    mode = 3'd5; burst_len = 5'd5; burst_start = 1'b1;
    tick();
    burst_start = 1'b0;
    chk("abort_busy_pre", busy, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0; mode = 3'd0;
    chk("abort_q", par_out, 8'h00);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    tick();
    chk("abort_after_done", done, 1'b0);
    chk("abort_after_busy", busy, 1'b0);
    exp_q = 8'h00;

    // Random single-cycle operations; burst_start only where it cannot start a burst.
    for (int i = 0; i < 60; i++) begin
      logic [2:0] m;
      logic       e;
      logic       st;
      m  = 3'($urandom);
      e  = ($urandom_range(0, 3) != 0);
      st = (!e || !shift_mode(m)) ? 1'($urandom) : 1'b0;
      op(m, 8'($urandom), 1'($urandom), 1'($urandom), e, st, "rand_op");
    end

    // Random bursts with random enable gaps and serial inputs.
    for (int i = 0; i < 12; i++) begin
      logic [2:0] m;
      int sel;
      sel = $urandom_range(0, 4);
      case (sel)
        0: m = 3'd1;
        1: m = 3'd2;
        2: m = 3'd4;
        3: m = 3'd5;
        default: m = 3'd6;
      endcase
      op(3'd3, 8'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, "rand_load");
      burst(m, $urandom_range(0, 19), 1'b1, 1'b1, "rand_burst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
